tensor_core_register_file: RTL and testbench

TENSOR_CORE_REGISTER_FILE -- requirements
Module: tensor_core_register_file

---
 rtl/tensor_core_register_file_if.sv | 38 +++
 rtl/tensor_core_register_file.sv | 151 +++++++++++++++
 tb/tb_tensor_core_register_file.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_register_file_if.sv
// Connection bundle for the tensor core register file: the operand load
// stream, the operand/result matrices exchanged with the tensor core, and
// the result stream with its status flags.
interface tensor_core_register_file_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0]             load_data_in;
   logic                              load_valid_in;
   logic                              load_ready_out;
   logic [3:0][3:0][DATA_WIDTH-1:0]   tensor_core_input1;
   logic [3:0][3:0][DATA_WIDTH-1:0]   tensor_core_input2;
   logic                              tensor_core_register_file_write_enable;
   logic [3:0][3:0][DATA_WIDTH-1:0]   tensor_core_output;
   logic                              is_done_with_calculation;
   logic [DATA_WIDTH-1:0]             result_data_out;
   logic                              result_valid_out;
   logic                              result_ready_in;
   logic                              busy_out;
   logic                              error_out;

   // View of the register file itself
   modport slave (
      input  load_data_in, load_valid_in, tensor_core_output,
             is_done_with_calculation, result_ready_in,
      output load_ready_out, tensor_core_input1, tensor_core_input2,
             tensor_core_register_file_write_enable, result_data_out,
             result_valid_out, busy_out, error_out
   );

   // View of everything around it (load source, tensor core, result sink)
   modport master (
      output load_data_in, load_valid_in, tensor_core_output,
             is_done_with_calculation, result_ready_in,
      input  load_ready_out, tensor_core_input1, tensor_core_input2,
             tensor_core_register_file_write_enable, result_data_out,
             result_valid_out, busy_out, error_out
   );
endinterface

// File: rtl/tensor_core_register_file.sv
// Tensor core register file: collects two 4x4 operand matrices from a
// beat stream, kicks the tensor core with a one-cycle pulse, waits for its
// completion flag (with a timeout), snapshots the product and streams it
// back out row-major. Element values are passed through bit-for-bit.
module tensor_core_register_file #(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic                        clock_in,
   input logic                        reset_in,
   tensor_core_register_file_if.slave bus
);

   localparam int WAIT_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD,
      START,
      WAIT,
      DRAIN
   } state_t;

   state_t                           state;
   state_t                           next_state;
   logic [4:0]                       load_idx;
   logic [3:0]                       result_idx;
   logic [WAIT_CNT_W-1:0]            wait_cnt;
   logic [3:0][3:0][DATA_WIDTH-1:0]  operand_a;
   logic [3:0][3:0][DATA_WIDTH-1:0]  operand_b;
   logic [3:0][3:0][DATA_WIDTH-1:0]  result_buffer;
   logic                             error_flag;

   logic load_accept;
   logic qualified_done;
   logic timeout_hit;
   logic result_xfer;

   // A done seen in the first WAIT cycle may be left over from the previous
   // job, so completion only counts once wait_cnt has moved off zero.
   assign load_accept    = (state == LOAD) && bus.load_valid_in;
   assign qualified_done = (state == WAIT) && (wait_cnt != '0) && bus.is_done_with_calculation;
   assign timeout_hit    = (state == WAIT) && !qualified_done && (wait_cnt == WAIT_LAST);
   assign result_xfer    = (state == DRAIN) && bus.result_ready_in;

   // State register
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state <= LOAD;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection and all state-derived outputs
   always_comb begin
      next_state                                 = state;
      bus.load_ready_out                         = 1'b0;
      bus.tensor_core_register_file_write_enable = 1'b0;
      bus.busy_out                               = 1'b0;
      bus.result_valid_out                       = 1'b0;
      bus.result_data_out                        = '0;
      bus.error_out                              = error_flag;
      bus.tensor_core_input1                     = operand_a;
      bus.tensor_core_input2                     = operand_b;
      case (state)
         LOAD: begin
            bus.load_ready_out = 1'b1;
            if (load_accept && (load_idx == 5'd31)) begin
               next_state = START;
            end
         end
         START: begin
            bus.tensor_core_register_file_write_enable = 1'b1;
            bus.busy_out                               = 1'b1;
            next_state                                 = WAIT;
         end
         WAIT: begin
            bus.busy_out = 1'b1;
            if (qualified_done) begin
               next_state = DRAIN;
            end else if (timeout_hit) begin
               next_state = LOAD;
            end
         end
         DRAIN: begin
            bus.result_valid_out = 1'b1;
            bus.result_data_out  = result_buffer[result_idx[3:2]][result_idx[1:0]];
            if (result_xfer && (result_idx == 4'd15)) begin
               next_state = LOAD;
            end
         end
         default: begin
            next_state = LOAD;
         end
      endcase
   end

   // Operand capture: beats 0-15 fill A, 16-31 fill B, row-major; the 5-bit
   // index wraps from 31 back to 0 on its own
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         load_idx  <= '0;
         operand_a <= '0;
         operand_b <= '0;
      end else if (load_accept) begin
         load_idx <= load_idx + 5'd1;
         if (load_idx[4]) begin
            operand_b[load_idx[3:2]][load_idx[1:0]] <= bus.load_data_in;
         end else begin
            operand_a[load_idx[3:2]][load_idx[1:0]] <= bus.load_data_in;
         end
      end
   end

   // Counts cycles spent in WAIT; cleared whenever WAIT is left or not entered
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         wait_cnt <= '0;
      end else if ((state == WAIT) && (next_state == WAIT)) begin
         wait_cnt <= wait_cnt + 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Product snapshot on qualified completion and result stream position
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         result_buffer <= '0;
         result_idx    <= '0;
      end else begin
         if (qualified_done) begin
            result_buffer <= bus.tensor_core_output;
         end
         if (result_xfer) begin
            result_idx <= result_idx + 4'd1;
         end
      end
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         error_flag <= 1'b0;
      end else if (timeout_hit) begin
         error_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_tensor_core_register_file.sv
// Self-checking bench for tensor_core_register_file: a table of operand
// pairs with expected products, randomized jobs, and hand-written sequences
// for stale done, timeout and reset in the middle of LOAD and DRAIN.
module tb_tensor_core_register_file;

   localparam int DW      = 8;
   localparam int TIMEOUT = 15;

   typedef logic [15:0][DW-1:0] mat_t;

   typedef struct packed {
      mat_t       a;
      mat_t       b;
      mat_t       expected;
      logic [3:0] latency;
      logic       gaps;
      logic [1:0] ready_mode;
   } vector_t;

   logic clock_in = 1'b0;
   logic reset_in = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   int we_count    = 0;
   int valid_count = 0;

   int core_latency = 2;
   bit core_stale   = 1'b0;
   bit core_hang    = 1'b0;

   tensor_core_register_file_if #(.DATA_WIDTH(DW)) tb_if ();

   tensor_core_register_file #(
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock_in(clock_in),
      .reset_in(reset_in),
      .bus(tb_if)
   );

   always #5 clock_in = ~clock_in;

   // Row-major 4x4 product with every element wrapped to DW bits
   function automatic mat_t matmul(input mat_t a, input mat_t b);
      mat_t r;
      int   sum;
      r = '0;
      for (int row = 0; row < 4; row++) begin
         for (int col = 0; col < 4; col++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) begin
               sum += int'($signed(a[row*4+k])) * int'($signed(b[k*4+col]));
            end
            r[row*4+col] = sum[DW-1:0];
         end
      end
      return r;
   endfunction

   function automatic mat_t random_mat();
      mat_t r;
      for (int i = 0; i < 16; i++) begin
         r[i] = DW'($urandom);
      end
      return r;
   endfunction

   // Counts cycles with write_enable and result_valid high
   always @(negedge clock_in) begin
      if (tb_if.tensor_core_register_file_write_enable) we_count++;
      if (tb_if.result_valid_out) valid_count++;
   end

   // Behavioural tensor core: multiplies its operand inputs some cycles after
   // the start pulse, holds done as a level, and scribbles on its output
   // while results drain so a live (non-snapshotted) path would show up
   initial begin : core_model
      int count;
      bit busy;
      int stale_left;
      count      = 0;
      busy       = 1'b0;
      stale_left = 0;
      tb_if.is_done_with_calculation = 1'b0;
      tb_if.tensor_core_output       = '0;
      forever begin
         @(negedge clock_in);
         if (tb_if.tensor_core_register_file_write_enable) begin
            busy  = 1'b1;
            count = core_latency;
            if (core_stale) begin
               stale_left = 1;
               tb_if.is_done_with_calculation = 1'b1;
               tb_if.tensor_core_output = {$urandom, $urandom, $urandom, $urandom};
            end else begin
               stale_left = 0;
               tb_if.is_done_with_calculation = 1'b0;
            end
         end else if (busy) begin
            if (stale_left > 0) begin
               stale_left--;
            end else begin
               tb_if.is_done_with_calculation = 1'b0;
               if (!core_hang) begin
                  if (count <= 1) begin
                     tb_if.tensor_core_output = matmul(tb_if.tensor_core_input1, tb_if.tensor_core_input2);
                     tb_if.is_done_with_calculation = 1'b1;
                     busy = 1'b0;
                  end else begin
                     count--;
                  end
               end
            end
         end else if (tb_if.result_valid_out) begin
            tb_if.tensor_core_output = {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Streams A then B as 32 beats; with gaps, valid drops every other cycle
   task automatic apply_stimulus(input mat_t a, input mat_t b, input bit gaps);
      for (int i = 0; i < 32; i++) begin
         if (gaps) begin
            @(negedge clock_in);
            tb_if.load_valid_in = 1'b0;
         end
         @(negedge clock_in);
         if (i == 0) check_output("load_ready_first_beat", tb_if.load_ready_out, 1);
         if (i == 31) begin
            check_output("load_ready_last_beat", tb_if.load_ready_out, 1);
            check_output("no_early_start", tb_if.tensor_core_register_file_write_enable, 0);
         end
         tb_if.load_valid_in = 1'b1;
         if (i < 16) tb_if.load_data_in = a[i];
         else        tb_if.load_data_in = b[i-16];
      end
      @(negedge clock_in);
      check_output("write_enable_after_load", tb_if.tensor_core_register_file_write_enable, 1);
      check_output("busy_in_start", tb_if.busy_out, 1);
      tb_if.load_valid_in = 1'b1;
      tb_if.load_data_in  = 8'h5A;
   endtask

   // Collects result beats; ready_mode 0 = always ready, 1 = three-cycle
   // stall after beat 0, 2 = random ready
   task automatic drain_results(input mat_t expected, input int ready_mode, input int beats);
      int   got;
      int   budget;
      int   stall_left;
      logic ready;
      got        = 0;
      budget     = 0;
      stall_left = 3;
      while (got < beats && budget < 200) begin
         @(negedge clock_in);
         budget++;
         ready = 1'b1;
         if (ready_mode == 1 && got == 1 && stall_left > 0) ready = 1'b0;
         else if (ready_mode == 2) ready = ($urandom_range(0, 2) != 0);
         tb_if.result_ready_in = ready;
         if (tb_if.result_valid_out) begin
            if (!ready && ready_mode == 1 && got == 1) begin
               check_output("held_beat_1", tb_if.result_data_out, expected[1]);
               stall_left--;
            end
            if (ready) begin
               check_output($sformatf("beat_%0d", got), tb_if.result_data_out, expected[got]);
               got++;
               if (got == beats) tb_if.load_valid_in = 1'b0;
            end
         end
      end
      check_output("drain_beats_within_budget", got, beats);
      if (beats == 16) begin
         @(negedge clock_in);
         check_output("valid_low_after_drain", tb_if.result_valid_out, 0);
         check_output("back_to_load", tb_if.load_ready_out, 1);
      end
   endtask

   task automatic run_vector(input vector_t v, input logic exp_error);
      int we_before;
      int valid_before;
      core_latency = int'(v.latency);
      #1;
      we_before    = we_count;
      valid_before = valid_count;
      apply_stimulus(v.a, v.b, v.gaps);
      drain_results(v.expected, int'(v.ready_mode), 16);
      #1;
      check_output("single_write_enable", we_count - we_before, 1);
      check_output("operands_stable_a", tb_if.tensor_core_input1, v.a);
      check_output("operands_stable_b", tb_if.tensor_core_input2, v.b);
      check_output("error_flag", tb_if.error_out, exp_error);
      if (v.ready_mode == 0) check_output("valid_cycles", valid_count - valid_before, 16);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_valid"}, tb_if.result_valid_out, 0);
      check_output({tag, "_data"}, tb_if.result_data_out, 0);
      check_output({tag, "_we"}, tb_if.tensor_core_register_file_write_enable, 0);
      check_output({tag, "_busy"}, tb_if.busy_out, 0);
      check_output({tag, "_error"}, tb_if.error_out, 0);
      check_output({tag, "_input1"}, tb_if.tensor_core_input1, 0);
      check_output({tag, "_input2"}, tb_if.tensor_core_input2, 0);
   endtask

   initial begin : main
      vector_t vecs[6];
      vector_t rv;
      mat_t    ident;
      mat_t    count_up;
      mat_t    all_neg;
      mat_t    neg_diag;
      int      k;
      int      valid_before;

      ident    = '0;
      neg_diag = '0;
      for (int i = 0; i < 4; i++) begin
         ident[i*5]    = 1;
         neg_diag[i*5] = 8'h80;
      end
      for (int i = 0; i < 16; i++) begin
         count_up[i] = DW'(i + 1);
         all_neg[i]  = 8'hFF;
      end

      vecs[0] = '{a: ident, b: count_up, expected: count_up, latency: 4'd2, gaps: 1'b0, ready_mode: 2'd0};
      vecs[1].a = random_mat();
      vecs[1].b = random_mat();
      vecs[1].expected = matmul(vecs[1].a, vecs[1].b);
      vecs[1].latency = 4'd4; vecs[1].gaps = 1'b1; vecs[1].ready_mode = 2'd0;
      vecs[2].a = random_mat();
      vecs[2].b = random_mat();
      vecs[2].expected = matmul(vecs[2].a, vecs[2].b);
      vecs[2].latency = 4'd1; vecs[2].gaps = 1'b0; vecs[2].ready_mode = 2'd1;
      vecs[3] = '{a: all_neg, b: count_up, expected: matmul(all_neg, count_up), latency: 4'd6, gaps: 1'b0, ready_mode: 2'd2};
      vecs[4] = '{a: neg_diag, b: ident, expected: neg_diag, latency: 4'd15, gaps: 1'b0, ready_mode: 2'd0};
      vecs[5] = '{a: ident, b: ident, expected: ident, latency: 4'd3, gaps: 1'b1, ready_mode: 2'd1};

      tb_if.load_valid_in   = 1'b0;
      tb_if.load_data_in    = '0;
      tb_if.result_ready_in = 1'b1;

      #2 reset_in = 1'b1;
      #1 check_reset_outputs("reset_initial");
      @(negedge clock_in);
      @(negedge clock_in);
      reset_in = 1'b0;
      @(negedge clock_in);
      check_output("ready_after_reset", tb_if.load_ready_out, 1);

      $display("[TB] table vectors");
      for (int v = 0; v < 6; v++) begin
         run_vector(vecs[v], 1'b0);
      end

      $display("[TB] randomized jobs");
      for (int n = 0; n < 4; n++) begin
         rv.a = random_mat();
         rv.b = random_mat();
         rv.expected   = matmul(rv.a, rv.b);
         rv.latency    = 4'($urandom_range(1, 12));
         rv.gaps       = 1'($urandom_range(0, 1));
         rv.ready_mode = 2'($urandom_range(0, 2));
         run_vector(rv, 1'b0);
      end

      $display("[TB] stale done");
      core_stale = 1'b1;
      rv.a = random_mat();
      rv.b = random_mat();
      rv.expected = matmul(rv.a, rv.b);
      rv.latency = 4'd3; rv.gaps = 1'b0; rv.ready_mode = 2'd0;
      run_vector(rv, 1'b0);
      core_stale = 1'b0;

      $display("[TB] reset mid-load");
      for (int i = 0; i < 10; i++) begin
         @(negedge clock_in);
         tb_if.load_valid_in = 1'b1;
         tb_if.load_data_in  = DW'($urandom_range(1, 255));
      end
      @(negedge clock_in);
      tb_if.load_valid_in = 1'b0;
      #2 reset_in = 1'b1;
      #1 check_output("mid_load_input1_cleared", tb_if.tensor_core_input1, 0);
      @(negedge clock_in);
      reset_in = 1'b0;
      run_vector(vecs[0], 1'b0);

      $display("[TB] reset mid-drain");
      core_latency = 2;
      apply_stimulus(vecs[3].a, vecs[3].b, 1'b0);
      drain_results(vecs[3].expected, 0, 5);
      #2 reset_in = 1'b1;
      #1 check_reset_outputs("mid_drain");
      @(negedge clock_in);
      reset_in = 1'b0;
      @(negedge clock_in);
      check_output("ready_after_mid_drain_reset", tb_if.load_ready_out, 1);
      run_vector(vecs[1], 1'b0);

      $display("[TB] timeout");
      core_hang = 1'b1;
      #1 valid_before = valid_count;
      apply_stimulus(vecs[2].a, vecs[2].b, 1'b0);
      tb_if.load_valid_in = 1'b0;
      k = 0;
      while (!tb_if.error_out && k < 40) begin
         @(negedge clock_in);
         k++;
      end
      check_output("timeout_cycles", k, 16);
      check_output("timeout_busy_low", tb_if.busy_out, 0);
      check_output("timeout_back_to_load", tb_if.load_ready_out, 1);
      repeat (3) @(negedge clock_in);
      #1;
      check_output("timeout_no_drain", valid_count - valid_before, 0);
      check_output("error_sticky", tb_if.error_out, 1);
      core_hang = 1'b0;
      run_vector(vecs[0], 1'b1);
      @(negedge clock_in);
      #2 reset_in = 1'b1;
      #1 check_output("error_cleared_by_reset", tb_if.error_out, 0);
      @(negedge clock_in);
      reset_in = 1'b0;
      @(negedge clock_in);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
